// File: rtl/icache_fill_ctrl.sv
// Instruction-cache line-RAM owner: hit lookup, 16-word miss refill and full
// flush sweep over an external 1024-line RAM with combinational read.
module icache_fill_ctrl #(
    parameter int unsigned INDEX_W = 10,
    parameter int unsigned WORDS   = 16,
    parameter int unsigned TAG_W   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    input  logic [31:0]                     req_addr,
    output logic                            resp_valid,
    output logic [31:0]                     resp_data,
    output logic                            busy,
    input  logic                            flush,
    output logic                            mem_req,
    output logic [31:0]                     mem_addr,
    input  logic                            mem_ack,
    input  logic [31:0]                     mem_rdata,
    output logic                            cache_we,
    output logic [INDEX_W-1:0]              cache_addr,
    output logic [1+TAG_W+32*WORDS-1:0]     cache_wdata,
    input  logic [1+TAG_W+32*WORDS-1:0]     cache_rdata
);

    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned DATA_W = 32 * WORDS;
    localparam int unsigned LINE_W = 1 + TAG_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FLUSH
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic [TAG_W-1:0]     tag_q;
    logic [INDEX_W-1:0]   index_q;
    logic [OFF_W-1:0]     fill_cnt;
    logic [INDEX_W-1:0]   sweep_cnt;
    logic                 flush_pending;
    logic [DATA_W-1:0]    line_buf;

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_index;
    logic [OFF_W-1:0]     req_off;
    logic                 flush_go;
    logic                 line_valid;
    logic [TAG_W-1:0]     line_tag;
    logic                 hit;
    logic [31:0]          sel_word;
    logic                 last_word;
    logic                 last_index;
    logic                 unused_addr_bits;

    assign req_tag          = req_addr[31 -: TAG_W];
    assign req_index        = req_addr[OFF_W+2 +: INDEX_W];
    assign req_off          = req_addr[2 +: OFF_W];
    assign unused_addr_bits = ^req_addr[1:0];

    assign flush_go   = flush | flush_pending;
    assign line_valid = cache_rdata[LINE_W-1];
    assign line_tag   = cache_rdata[LINE_W-2 -: TAG_W];
    assign hit        = req_valid && line_valid && (line_tag == req_tag);
    assign sel_word   = cache_rdata[{req_off, 5'd0} +: 32];
    assign last_word  = (fill_cnt == OFF_W'(WORDS - 1));
    assign last_index = &sweep_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (flush_go) begin
                    state_nx = FLUSH;
                end else if (req_valid && !hit) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (mem_ack && last_word) begin
                    state_nx = WRITE;
                end
            end
            WRITE: state_nx = IDLE;
            FLUSH: begin
                if (last_index) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Flushes arriving mid-fill are remembered so the fill still lands first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q         <= '0;
            index_q       <= '0;
            fill_cnt      <= '0;
            sweep_cnt     <= '0;
            flush_pending <= 1'b0;
            line_buf      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_go) begin
                        flush_pending <= 1'b0;
                        sweep_cnt     <= '0;
                    end else if (req_valid && !hit) begin
                        tag_q    <= req_tag;
                        index_q  <= req_index;
                        fill_cnt <= '0;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (mem_ack) begin
                        line_buf[{fill_cnt, 5'd0} +: 32] <= mem_rdata;
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                end
                FLUSH: sweep_cnt <= sweep_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs are forced low while rst is held so the bus is quiet immediately.
    always_comb begin
        resp_valid  = 1'b0;
        resp_data   = '0;
        busy        = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        cache_we    = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    cache_addr = req_valid ? req_index : index_q;
                    if (!flush_go && hit) begin
                        resp_valid = 1'b1;
                        resp_data  = sel_word;
                    end
                end
                FILL: begin
                    busy     = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {tag_q, index_q, fill_cnt, 2'b00};
                end
                WRITE: begin
                    busy        = 1'b1;
                    cache_we    = 1'b1;
                    cache_addr  = index_q;
                    cache_wdata = {1'b1, tag_q, line_buf};
                end
                FLUSH: begin
                    busy       = 1'b1;
                    cache_we   = 1'b1;
                    cache_addr = sweep_cnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: directed cases then randomized fetches,
// checked against a line-level cache model and an address-derived memory.
module tb_icache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         flush = 1'b0;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         cache_we;
    logic [9:0]   cache_addr;
    logic [528:0] cache_wdata;
    logic [528:0] cache_rdata;

    logic [528:0] ram [1024] = '{default: '0};

    int errors = 0;
    int checks = 0;

    logic [31:0]  salt = '0;
    logic [31:0]  resp_q [$];
    logic [31:0]  fill_q [$];
    logic [538:0] wr_q [$];

    bit           m_valid [1024];
    logic [15:0]  m_tag   [1024];
    logic [31:0]  m_word  [1024][16];

    int flush_writes = 0;
    int exp_flush_writes = 0;
    int flush_next = 0;
    bit stall_once = 1'b0;
    bit rand_stall = 1'b0;

    icache_fill_ctrl #(
        .INDEX_W (10),
        .WORDS   (16),
        .TAG_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .busy        (busy),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .cache_we    (cache_we),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_rdata (cache_rdata)
    );

    always #5 clk = ~clk;

    assign cache_rdata = ram[cache_addr];
    always @(posedge clk) if (cache_we) ram[cache_addr] <= cache_wdata;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ salt;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[a[15:6]] && (m_tag[a[15:6]] == a[31:16]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [538:0] act, input logic [538:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({resp_valid, busy, mem_req, cache_we} !== 4'b0 || mem_addr !== '0 ||
            cache_addr !== '0 || cache_wdata !== '0 || resp_data !== '0) begin
            errors++;
            $display("FAIL %s: outputs not zero rv=%b busy=%b mreq=%b we=%b maddr=%h caddr=%h rdata=%h",
                     name, resp_valid, busy, mem_req, cache_we, mem_addr, cache_addr, resp_data);
        end
    endtask

    task automatic model_clear();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int zeros = 0;
        for (int i = 0; i < 3000 && zeros < 2; i++) begin
            @(negedge clk);
            zeros = busy ? 0 : zeros + 1;
        end
        checks++;
        if (zeros < 2) begin
            errors++;
            $display("FAIL %s: busy still %b after 3000 cycles, required 0", name, busy);
        end
    endtask

    task automatic wait_acks(input int n);
        int cnt = 0;
        for (int i = 0; i < 500 && cnt < n; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) cnt++;
        end
        checks++;
        if (cnt < n) begin
            errors++;
            $display("FAIL ack_wait: saw %0d acks, required %0d", cnt, n);
        end
    endtask

    // One presentation of a fetch; a miss runs to completion of the refill.
    task automatic present(input logic [31:0] a, input bit with_flush, input int mid_ack,
                           input bit mid_rst, output bit missed);
        logic [9:0]   idx;
        logic [15:0]  tg;
        logic [3:0]   off;
        logic [528:0] line;
        logic [31:0]  wa;
        bit           old_v;
        logic [15:0]  old_t;
        logic [31:0]  old_w [16];
        idx = a[15:6];
        tg  = a[31:16];
        off = a[5:2];
        missed = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        flush     = with_flush;
        if (with_flush) begin
            @(negedge clk);
            check("flush_req_no_resp", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
            flush = 1'b0;
            req_valid = 1'b0;
            exp_flush_writes += 1024;
            wait_idle("flush_idle");
            model_clear();
        end else if (m_hit(a)) begin
            resp_q.push_back(m_word[idx][off]);
            @(negedge clk);
            check("hit_resp_valid", 32'(resp_valid), 32'd1);
            @(posedge clk); #1;
            req_valid = 1'b0;
        end else begin
            missed = 1'b1;
            old_v = m_valid[idx];
            old_t = m_tag[idx];
            for (int unsigned w = 0; w < 16; w++) old_w[w] = m_word[idx][w];
            line = '0;
            line[528] = 1'b1;
            line[527:512] = tg;
            for (int unsigned w = 0; w < 16; w++) begin
                wa = {tg, idx, w[3:0], 2'b00};
                fill_q.push_back(wa);
                line[32*w +: 32] = memfn(wa);
                m_word[idx][w] = memfn(wa);
            end
            wr_q.push_back({idx, line});
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
            @(negedge clk);
            check("miss_no_resp", 32'(resp_valid), 32'd0);
            check("miss_idle_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_addr  = $urandom;
            check("fill_busy", 32'(busy), 32'd1);
            if (mid_ack > 0) begin
                wait_acks(mid_ack);
                if (mid_rst) begin
                    #1 rst = 1'b1;
                    #1 check_outputs_zero("rst_mid_fill");
                    fill_q.delete();
                    wr_q.delete();
                    m_valid[idx] = old_v;
                    m_tag[idx] = old_t;
                    for (int unsigned w = 0; w < 16; w++) m_word[idx][w] = old_w[w];
                    @(posedge clk); #1;
                    rst = 1'b0;
                end else begin
                    @(posedge clk); #1 flush = 1'b1;
                    @(posedge clk); #1 flush = 1'b0;
                    exp_flush_writes += 1024;
                end
            end
            wait_idle("fill_idle");
            if (mid_ack > 0 && !mid_rst) model_clear();
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        bit m;
        present(a, 1'b0, 0, 1'b0, m);
        if (m) present(a, 1'b0, 0, 1'b0, m);
    endtask

    // Memory responder and fill-address monitor.
    initial begin
        int stall_left = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (fill_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req_unexpected: mem_req=1 addr %h, required no request", mem_addr);
                end else begin
                    check("mem_addr", mem_addr, fill_q[0]);
                    if (mem_ack) begin
                        void'(fill_q.pop_front());
                        if (stall_once && fill_q.size() == 10) begin
                            stall_left = 3;
                            stall_once = 1'b0;
                        end
                    end
                end
            end
            @(posedge clk); #1;
            if (mem_req && !rst) begin
                if (stall_left > 0) begin
                    stall_left--;
                    mem_ack = 1'b0;
                end else if (rand_stall) begin
                    mem_ack = ($urandom_range(0, 3) != 0);
                end else begin
                    mem_ack = 1'b1;
                end
            end else begin
                mem_ack = 1'b0;
            end
            mem_rdata = mem_ack ? memfn(mem_addr) : $urandom;
        end
    end

    // Line-RAM write monitor.
    initial begin
        logic [538:0] e;
        forever begin
            @(negedge clk);
            if (cache_we) begin
                if (cache_wdata[528]) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL line_write_unexpected: write to index %h, required none", cache_addr);
                    end else begin
                        e = wr_q.pop_front();
                        check_w("line_write", {cache_addr, cache_wdata}, e);
                    end
                end else begin
                    check("flush_addr", 32'(cache_addr), 32'(flush_next));
                    check("flush_data", 32'(|cache_wdata), 32'd0);
                    flush_next = (flush_next + 1) % 1024;
                    flush_writes++;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                check("resp_not_busy", 32'(busy), 32'd0);
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: resp_data %h, required no response", resp_data);
                end else begin
                    check("resp_data", resp_data, resp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        logic [31:0] a;
        logic [9:0] idx_pool [5];
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        fetch(32'h0000_1044);
        fetch(32'h0000_1040);
        fetch(32'h0001_1040);
        present(32'h0000_1040, 1'b0, 0, 1'b0, m);
        check("conflict_miss", 32'(m), 32'd1);
        fetch(32'h0000_1040);

        stall_once = 1'b1;
        fetch(32'h0002_1058);

        present(32'h0003_2000, 1'b0, 8, 1'b0, m);
        present(32'h0003_2000, 1'b0, 0, 1'b0, m);
        check("after_flush_miss", 32'(m), 32'd1);
        fetch(32'h0003_2004);

        present(32'h0004_3008, 1'b0, 10, 1'b1, m);
        fetch(32'h0004_3008);

        fetch(32'h0000_1044);
        present(32'h0000_1044, 1'b1, 0, 1'b0, m);
        present(32'h0000_1044, 1'b0, 0, 1'b0, m);
        check("flush_req_then_miss", 32'(m), 32'd1);

        salt = $urandom;
        rand_stall = 1'b1;
        idx_pool[0] = 10'h041;
        idx_pool[1] = 10'h000;
        idx_pool[2] = 10'h3FF;
        idx_pool[3] = 10'h155;
        idx_pool[4] = 10'h2AA;
        for (int i = 0; i < 80; i++) begin
            a = {16'($urandom_range(0, 2)), idx_pool[$urandom_range(0, 4)],
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 39) == 0) present(a, 1'b1, 0, 1'b0, m);
            else if ($urandom_range(0, 2) == 0) fetch(a);
            else present(a, 1'b0, 0, 1'b0, m);
        end

        repeat (4) @(negedge clk);
        check("flush_write_count", 32'(flush_writes), 32'(exp_flush_writes));
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("fill_q_drained", 32'(fill_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
